// File: rtl/cmsdk_irq_sync_multi_pkg.sv
// Shared definitions for the multi-channel IRQ synchroniser: parameter limits, mode encodings, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmsdk_irq_sync_multi_pkg;

   // Legal parameter ranges
   localparam int NUM_IRQ_MIN     = 1;
   localparam int NUM_IRQ_MAX     = 32;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int FILTER_LEN_MIN  = 1;
   localparam int FILTER_LEN_MAX  = 15;

   // Per-channel IRQMODE encoding
   typedef enum logic {
      IRQ_MODE_LEVEL = 1'b0,
      IRQ_MODE_EDGE  = 1'b1
   } irq_mode_e;

   // Width of the filter hold counter; one spare bit keeps FILTER_LEN=1 at a legal 1-bit width
   function automatic int cnt_width(input int filter_len);
      return $clog2(filter_len) + 1;
   endfunction

endpackage

// File: rtl/cmsdk_irq_sync_multi_chan.sv
// One IRQ channel: synchroniser chain, glitch filter, and edge-mode pending latch.
// Latency: SYNC_STAGES+FILTER_LEN edges from first sampling edge to filtered level update.
// Backpressure: none; IRQ lines are plain levels and the pending flag waits for IRQCLR.
module cmsdk_irq_sync_chan
   import cmsdk_irq_sync_multi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 1
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic IRQIN,
   input  logic IRQMODE,
   input  logic IRQCLR,
   output logic IRQOUT,
   output logic IRQSTATUS
);

   localparam int            CW     = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_lvl;
   logic                   f_q;
   logic                   f_d;
   logic [CW-1:0]          c_q;
   logic [CW-1:0]          c_d;
   logic                   p_q;
   logic                   p_d;
   logic                   accept;
   logic                   rise;

   assign s_lvl = sync_q[SYNC_STAGES-1];

   // Metastability chain: shift the raw asynchronous request toward the last stage
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], IRQIN};
      end
   end

   // Filter: accept a new synchronised level only after it has differed from F for FILTER_LEN edges
   always_comb begin
      f_d    = f_q;
      c_d    = c_q;
      accept = 1'b0;
      if (s_lvl == f_q) begin
         c_d = '0;
      end else if (c_q == C_LAST) begin
         f_d    = s_lvl;
         c_d    = '0;
         accept = 1'b1;
      end else begin
         c_d = c_q + CW'(1);
      end
   end

   // A rising event is the filter accepting a 0->1 change; a mode switch alone never creates one
   assign rise = accept & s_lvl;

   // Pending flag: held clear in level mode, set beats clear in edge mode
   always_comb begin
      p_d = p_q;
      if (IRQMODE == IRQ_MODE_LEVEL) begin
         p_d = 1'b0;
      end else if (rise) begin
         p_d = 1'b1;
      end else if (IRQCLR) begin
         p_d = 1'b0;
      end
   end

   // Filter and pending state registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         f_q <= 1'b0;
         c_q <= '0;
         p_q <= 1'b0;
      end else begin
         f_q <= f_d;
         c_q <= c_d;
         p_q <= p_d;
      end
   end

   assign IRQOUT    = (IRQMODE == IRQ_MODE_EDGE) ? p_q : f_q;
   assign IRQSTATUS = f_q;

endmodule

// File: rtl/cmsdk_irq_sync_multi.sv
// Multi-channel IRQ synchroniser/filter: NUM_IRQ independent copies of cmsdk_irq_sync_chan.
// Latency: SYNC_STAGES+FILTER_LEN edges per channel, all channels in parallel.
// Backpressure: none; edge-mode events stay pending until IRQCLR.
module cmsdk_irq_sync_multi
   import cmsdk_irq_sync_multi_pkg::*;
#(
   parameter int NUM_IRQ     = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 1
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic [NUM_IRQ-1:0] IRQIN,
   input  logic [NUM_IRQ-1:0] IRQMODE,
   input  logic [NUM_IRQ-1:0] IRQCLR,
   output logic [NUM_IRQ-1:0] IRQOUT,
   output logic [NUM_IRQ-1:0] IRQSTATUS
);

   // Reject unsupported configurations at elaboration
   if ((NUM_IRQ < NUM_IRQ_MIN) || (NUM_IRQ > NUM_IRQ_MAX) ||
       (SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX) ||
       (FILTER_LEN < FILTER_LEN_MIN) || (FILTER_LEN > FILTER_LEN_MAX)) begin : g_param_err
      $error("cmsdk_irq_sync_multi: parameter out of range (NUM_IRQ=%0d SYNC_STAGES=%0d FILTER_LEN=%0d)",
             NUM_IRQ, SYNC_STAGES, FILTER_LEN);
   end

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
      cmsdk_irq_sync_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_chan (
         .CLK       (CLK),
         .RSTn      (RSTn),
         .IRQIN     (IRQIN[i]),
         .IRQMODE   (IRQMODE[i]),
         .IRQCLR    (IRQCLR[i]),
         .IRQOUT    (IRQOUT[i]),
         .IRQSTATUS (IRQSTATUS[i])
      );
   end

endmodule

// File: tb/tb_cmsdk_irq_sync_multi.sv
// Bench for cmsdk_irq_sync_multi: two configurations driven with shared stimulus and a window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cmsdk_irq_sync_multi;

   localparam int N      = 32;
   localparam int SYNC_A = 2;
   localparam int FL_A   = 1;
   localparam int SYNC_B = 3;
   localparam int FL_B   = 4;

   logic         CLK = 1'b0;
   logic         RSTn;
   logic [N-1:0] IRQIN;
   logic [N-1:0] IRQMODE;
   logic [N-1:0] IRQCLR;
   logic [N-1:0] a_out;
   logic [N-1:0] a_st;
   logic [N-1:0] b_out;
   logic [N-1:0] b_st;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   cmsdk_irq_sync_multi #(.NUM_IRQ(N), .SYNC_STAGES(SYNC_A), .FILTER_LEN(FL_A)) dut_a (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .IRQIN     (IRQIN),
      .IRQMODE   (IRQMODE),
      .IRQCLR    (IRQCLR),
      .IRQOUT    (a_out),
      .IRQSTATUS (a_st)
   );

   cmsdk_irq_sync_multi #(.NUM_IRQ(N), .SYNC_STAGES(SYNC_B), .FILTER_LEN(FL_B)) dut_b (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .IRQIN     (IRQIN),
      .IRQMODE   (IRQMODE),
      .IRQCLR    (IRQCLR),
      .IRQOUT    (b_out),
      .IRQSTATUS (b_st)
   );

   // ---------------- reference model ----------------
   // hist holds the raw IRQIN samples taken at past edges (bit 0 = previous edge).
   // The filtered level flips when the last FILTER_LEN synchronised samples all
   // disagree with it; the synchronised sample at an edge is the raw sample taken
   // SYNC_STAGES edges earlier.
   bit [31:0] hist [2][N];
   bit        mf   [2][N];
   bit        mp   [2][N];

   function automatic int sync_of(input int k);
      return (k == 0) ? SYNC_A : SYNC_B;
   endfunction

   function automatic int fl_of(input int k);
      return (k == 0) ? FL_A : FL_B;
   endfunction

   function automatic logic [1:0] model_step(input bit [31:0] h, input bit f, input bit p,
                                             input int sync, input int fl,
                                             input logic mode, input logic clr);
      logic all_diff;
      logic nf;
      logic np;
      all_diff = 1'b1;
      for (int k = sync - 1; k <= sync + fl - 2; k++) begin
         if (h[k] == f) all_diff = 1'b0;
      end
      nf = all_diff ? ~f : f;
      if (mode == 1'b0)          np = 1'b0;
      else if (all_diff && !f)   np = 1'b1;
      else if (clr)              np = 1'b0;
      else                       np = p;
      return {nf, np};
   endfunction

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
               hist[k][c] <= '0;
               mf[k][c]   <= 1'b0;
               mp[k][c]   <= 1'b0;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
               {mf[k][c], mp[k][c]} <= model_step(hist[k][c], mf[k][c], mp[k][c],
                                                  sync_of(k), fl_of(k), IRQMODE[c], IRQCLR[c]);
               hist[k][c] <= {hist[k][c][30:0], IRQIN[c]};
            end
         end
      end
   end

   function automatic logic [N-1:0] exp_out(input int k);
      logic [N-1:0] r;
      for (int c = 0; c < N; c++) r[c] = IRQMODE[c] ? mp[k][c] : mf[k][c];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_st(input int k);
      logic [N-1:0] r;
      for (int c = 0; c < N; c++) r[c] = mf[k][c];
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, away from the rising edge, both DUTs must match the model
   always @(negedge CLK) begin
      chk("A_irqout", a_out, exp_out(0));
      chk("A_status", a_st,  exp_st(0));
      chk("B_irqout", b_out, exp_out(1));
      chk("B_status", b_st,  exp_st(1));
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic seen;
      int   idx;
      RSTn    = 1'b0;
      IRQIN   = '0;
      IRQMODE = '0;
      IRQCLR  = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_a_out", a_out, '0);
      chk("rst_b_out", b_out, '0);
      chk("rst_a_st",  a_st,  '0);
      @(negedge CLK);
      RSTn = 1'b1;
      step();
      chk("rel_first_a", a_out, '0);
      repeat (3) step();

      // Level mode, A: rise visible after the 3rd sampling edge, fall likewise
      IRQIN[0] = 1'b1;
      step(); chk1("lvl0_e1", a_out[0], 1'b0);
      step(); chk1("lvl0_e2", a_out[0], 1'b0);
      step(); chk1("lvl0_e3", a_out[0], 1'b1);
      chk1("lvl0_st", a_st[0], 1'b1);
      IRQIN[0] = 1'b0;
      step(); chk1("lvl0_f1", a_out[0], 1'b1);
      step(); chk1("lvl0_f2", a_out[0], 1'b1);
      step(); chk1("lvl0_f3", a_out[0], 1'b0);
      repeat (10) step();

      // Filter, B: a 3-cycle glitch is rejected, a 4-cycle pulse is accepted after SYNC+4 edges
      IRQIN[5] = 1'b1;
      repeat (3) step();
      IRQIN[5] = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         step();
         seen = seen | b_out[5] | b_st[5];
      end
      chk1("glitch3_b5", seen, 1'b0);
      IRQIN[5] = 1'b1;
      repeat (4) step();
      IRQIN[5] = 1'b0;
      step(); step();
      chk1("pulse4_b5_e6", b_st[5], 1'b0);
      step();
      chk1("pulse4_b5_e7", b_out[5], 1'b1);
      chk1("pulse4_b5_st", b_st[5], 1'b1);
      repeat (12) step();

      // Edge mode, A channel 3: latching, no count, clear, set beats clear
      IRQMODE[3] = 1'b1;
      repeat (2) step();
      chk1("e3_idle", a_out[3], 1'b0);
      IRQIN[3] = 1'b1;
      repeat (3) step();
      chk1("e3_rise1", a_out[3], 1'b1);
      IRQIN[3] = 1'b0;
      repeat (17) step();
      chk1("e3_hold", a_out[3], 1'b1);
      IRQIN[3] = 1'b1;
      repeat (3) step();
      chk1("e3_rise2", a_out[3], 1'b1);
      IRQIN[3] = 1'b0;
      repeat (5) step();
      chk1("e3_still", a_out[3], 1'b1);
      IRQCLR[3] = 1'b1;
      step();
      chk1("e3_clr", a_out[3], 1'b0);
      IRQCLR[3] = 1'b0;
      repeat (3) step();
      IRQIN[3] = 1'b1;
      repeat (2) step();
      IRQCLR[3] = 1'b1;
      step();
      chk1("e3_set_wins", a_out[3], 1'b1);
      IRQCLR[3] = 1'b0;
      IRQIN[3]  = 1'b0;
      repeat (4) step();
      IRQCLR[3] = 1'b1;
      step();
      chk1("e3_clr2", a_out[3], 1'b0);
      IRQCLR[3]  = 1'b0;
      IRQMODE[3] = 1'b0;
      repeat (3) step();

      // Mode 1->0 drops pending on A channel 2
      IRQMODE[2] = 1'b1;
      IRQIN[2]   = 1'b1;
      repeat (3) step();
      chk1("m2_set", a_out[2], 1'b1);
      IRQIN[2] = 1'b0;
      repeat (4) step();
      chk1("m2_pend", a_out[2], 1'b1);
      IRQMODE[2] = 1'b0;
      step();
      chk1("m2_lvl", a_out[2], 1'b0);
      IRQMODE[2] = 1'b1;
      step();
      chk1("m2_p_gone", a_out[2], 1'b0);
      IRQMODE[2] = 1'b0;

      // Mode 0->1 with F already high creates no event (A channel 9)
      IRQIN[9] = 1'b1;
      repeat (3) step();
      chk1("m9_lvl_hi", a_out[9], 1'b1);
      IRQMODE[9] = 1'b1;
      repeat (3) step();
      chk1("m9_no_event", a_out[9], 1'b0);
      IRQMODE[9] = 1'b0;
      IRQIN[9]   = 1'b0;
      repeat (10) step();

      // Async reset mid-filter with P[7]=1 on B, IRQIN[7] held high through release
      IRQMODE[7] = 1'b1;
      IRQIN[7]   = 1'b1;
      repeat (7) step();
      chk1("b7_set", b_out[7], 1'b1);
      IRQIN[6] = 1'b1;
      repeat (5) step();
      #2 RSTn = 1'b0;
      #1;
      chk("arst_a_out", a_out, '0);
      chk("arst_a_st",  a_st,  '0);
      chk("arst_b_out", b_out, '0);
      chk("arst_b_st",  b_st,  '0);
      @(posedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      step();
      chk("rel_e1_a_out", a_out, '0);
      chk("rel_e1_b_out", b_out, '0);
      chk("rel_e1_b_st",  b_st,  '0);
      seen = 1'b0;
      repeat (5) begin
         step();
         seen = seen | b_out[7];
      end
      chk1("b7_quiet", seen, 1'b0);
      step();
      chk1("b7_reset_e7", b_out[7], 1'b1);
      IRQIN   = '0;
      IRQMODE = '0;
      repeat (12) step();

      // All channels toggled together, alternating modes, slow then fast
      IRQMODE = 32'hAAAA_AAAA;
      repeat (12) begin
         IRQIN = ~IRQIN;
         repeat (8) step();
      end
      repeat (12) begin
         IRQIN = ~IRQIN;
         repeat (3) step();
      end
      IRQCLR = '1;
      step();
      IRQCLR = '0;

      // Random traffic with sparse mode flips and occasional async resets
      repeat (3000) begin
         IRQIN  = IRQIN ^ ($urandom & $urandom & $urandom);
         IRQCLR = $urandom & $urandom;
         if ($urandom_range(0, 63) == 0) begin
            idx = $urandom_range(0, N - 1);
            IRQMODE[idx] = ~IRQMODE[idx];
         end
         if ($urandom_range(0, 399) == 0) begin
            #2 RSTn = 1'b0;
            @(negedge CLK);
            RSTn = 1'b1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
